// File: rtl/hx8352_pixel_streamer.sv
// Test-pattern pixel source for the HX8352 LCD controller.
// Streams one H_RES x V_RES RGB565 frame per accepted start over a valid/ready
// handshake. Supported patterns are solid, colour bars, checkerboard and gradient.
module hx8352_pixel_streamer #(
    parameter int unsigned H_RES      = 240,
    parameter int unsigned V_RES      = 400,
    parameter int unsigned BARS       = 8,
    parameter int unsigned CHECK_LOG2 = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        init_done,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] fg_color,
    input  logic        pixel_ready,
    output logic        pixel_valid,
    output logic [15:0] pixel_data,
    output logic        frame_first,
    output logic        frame_done,
    output logic        busy,
    output logic [8:0]  x,
    output logic [8:0]  y
);

    // Reject geometries that the 9-bit coordinates or the bar sub-counter cannot represent.
    if (H_RES == 0 || H_RES > 512 || V_RES == 0 || V_RES > 512) begin : g_bad_res
        $error("hx8352_pixel_streamer: H_RES and V_RES must be in 1..512");
    end
    if (BARS != 8 || (H_RES % BARS) != 0) begin : g_bad_bars
        $error("hx8352_pixel_streamer: BARS must be 8 and must divide H_RES");
    end
    if (CHECK_LOG2 > 8) begin : g_bad_check
        $error("hx8352_pixel_streamer: CHECK_LOG2 must index a 9-bit coordinate");
    end

    localparam int unsigned BarWidth = H_RES / BARS;
    localparam logic [8:0]  XLast    = 9'(H_RES - 1);
    localparam logic [8:0]  YLast    = 9'(V_RES - 1);
    localparam logic [8:0]  BarLast  = 9'(BarWidth - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e      state;
    logic [1:0]  mode_q;
    logic [15:0] fg_q;
    logic [8:0]  bar_cnt;
    logic [2:0]  bar_idx;

    logic [8:0]  x_nxt, y_nxt, cnt_nxt;
    logic [2:0]  idx_nxt;
    logic [1:0]  mode_sel;
    logic [15:0] fg_sel, bar_color, pix_nxt;
    logic        last_col, last_pix, start_ok;

    assign last_col = (x == XLast);
    assign last_pix = last_col && (y == YLast);
    // A start in the frame_done cycle is dropped so a frame always ends with one idle cycle.
    assign start_ok = start && init_done && !frame_done;

    // Coordinates and bar position of the pixel that follows the current one.
    always_comb begin
        x_nxt    = x;
        y_nxt    = y;
        cnt_nxt  = bar_cnt;
        idx_nxt  = bar_idx;
        mode_sel = mode_q;
        fg_sel   = fg_q;
        if (state == StIdle) begin
            // The first pixel is built from the live inputs, latched on the same edge.
            x_nxt    = '0;
            y_nxt    = '0;
            cnt_nxt  = '0;
            idx_nxt  = '0;
            mode_sel = mode;
            fg_sel   = fg_color;
        end else if (last_col) begin
            x_nxt   = '0;
            y_nxt   = y + 9'd1;
            cnt_nxt = '0;
            idx_nxt = '0;
        end else begin
            x_nxt = x + 9'd1;
            if (bar_cnt == BarLast) begin
                cnt_nxt = '0;
                idx_nxt = bar_idx + 3'd1;
            end else begin
                cnt_nxt = bar_cnt + 9'd1;
            end
        end
    end

    // Colour bar palette and pattern mux for the next pixel.
    always_comb begin
        bar_color = 16'h0000;
        unique case (idx_nxt)
            3'd0: bar_color = 16'hFFFF;
            3'd1: bar_color = 16'hFFE0;
            3'd2: bar_color = 16'h07FF;
            3'd3: bar_color = 16'h07E0;
            3'd4: bar_color = 16'hF81F;
            3'd5: bar_color = 16'hF800;
            3'd6: bar_color = 16'h001F;
            3'd7: bar_color = 16'h0000;
            default: bar_color = 16'h0000;
        endcase
        pix_nxt = fg_sel;
        case (mode_sel)
            2'd0: pix_nxt = fg_sel;
            2'd1: pix_nxt = bar_color;
            2'd2: pix_nxt = (x_nxt[CHECK_LOG2] ^ y_nxt[CHECK_LOG2]) ? ~fg_sel : fg_sel;
            default: pix_nxt = {x_nxt[7:3], y_nxt[8:3], x_nxt[7:3]};
        endcase
    end

    // Frame FSM with registered handshake, coordinates and status outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= StIdle;
            mode_q      <= 2'd0;
            fg_q        <= 16'h0000;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            pixel_valid <= 1'b0;
            pixel_data  <= 16'h0000;
            frame_first <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start_ok) begin
                        mode_q      <= mode;
                        fg_q        <= fg_color;
                        x           <= x_nxt;
                        y           <= y_nxt;
                        bar_cnt     <= cnt_nxt;
                        bar_idx     <= idx_nxt;
                        pixel_data  <= pix_nxt;
                        pixel_valid <= 1'b1;
                        frame_first <= 1'b1;
                        busy        <= 1'b1;
                        state       <= StStream;
                    end
                end
                StStream: begin
                    if (!init_done) begin
                        // Abort: drop the frame silently, no frame_done.
                        pixel_valid <= 1'b0;
                        frame_first <= 1'b0;
                        busy        <= 1'b0;
                        x           <= '0;
                        y           <= '0;
                        bar_cnt     <= '0;
                        bar_idx     <= '0;
                        state       <= StIdle;
                    end else if (pixel_ready) begin
                        if (last_pix) begin
                            pixel_valid <= 1'b0;
                            frame_first <= 1'b0;
                            busy        <= 1'b0;
                            frame_done  <= 1'b1;
                            x           <= '0;
                            y           <= '0;
                            bar_cnt     <= '0;
                            bar_idx     <= '0;
                            state       <= StIdle;
                        end else begin
                            x           <= x_nxt;
                            y           <= y_nxt;
                            bar_cnt     <= cnt_nxt;
                            bar_idx     <= idx_nxt;
                            pixel_data  <= pix_nxt;
                            frame_first <= 1'b0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hx8352_pixel_streamer.sv
// Self-checking bench for hx8352_pixel_streamer: table of spot pixels plus
// hand-written protocol sequences (back-pressure, abort, reset, re-start).
module tb_hx8352_pixel_streamer;

    localparam int HA = 16;
    localparam int VA = 4;
    localparam logic [15:0] BAR_COL [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst, init_done, start, ready, start_big;
    logic [1:0]  mode;
    logic [15:0] fg;

    logic        a_valid, a_first, a_done, a_busy;
    logic [15:0] a_data;
    logic [8:0]  a_x, a_y;
    logic        b_valid, b_first, b_done, b_busy;
    logic [15:0] b_data;
    logic [8:0]  b_x, b_y;
    logic        c_valid, c_first, c_done, c_busy;
    logic [15:0] c_data;
    logic [8:0]  c_x, c_y;

    hx8352_pixel_streamer #(.H_RES(HA), .V_RES(VA), .BARS(8), .CHECK_LOG2(1)) u_a (
        .clk(clk), .n_rst(n_rst), .init_done(init_done), .start(start), .mode(mode),
        .fg_color(fg), .pixel_ready(ready), .pixel_valid(a_valid), .pixel_data(a_data),
        .frame_first(a_first), .frame_done(a_done), .busy(a_busy), .x(a_x), .y(a_y)
    );

    hx8352_pixel_streamer #(.H_RES(240), .V_RES(4), .BARS(8), .CHECK_LOG2(4)) u_b (
        .clk(clk), .n_rst(n_rst), .init_done(1'b1), .start(start_big), .mode(2'd3),
        .fg_color(16'h0000), .pixel_ready(1'b1), .pixel_valid(b_valid), .pixel_data(b_data),
        .frame_first(b_first), .frame_done(b_done), .busy(b_busy), .x(b_x), .y(b_y)
    );

    hx8352_pixel_streamer #(.H_RES(8), .V_RES(400), .BARS(8), .CHECK_LOG2(4)) u_c (
        .clk(clk), .n_rst(n_rst), .init_done(1'b1), .start(start_big), .mode(2'd3),
        .fg_color(16'h0000), .pixel_ready(1'b1), .pixel_valid(c_valid), .pixel_data(c_data),
        .frame_first(c_first), .frame_done(c_done), .busy(c_busy), .x(c_x), .y(c_y)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference pattern written with a divider for the bar index.
    function automatic int model(input int m, input int f, input int px, input int py,
                                 input int hres, input int cl2);
        int b;
        case (m)
            0: return f;
            1: begin
                b = px / (hres / 8);
                return int'(BAR_COL[b[2:0]]);
            end
            2: return ((((px >> cl2) ^ (py >> cl2)) & 1) != 0) ? (~f & 16'hFFFF) : f;
            default: return (((px >> 3) & 31) << 11) | (((py >> 3) & 63) << 5) | ((px >> 3) & 31);
        endcase
    endfunction

    logic [15:0] cap [HA*VA];
    logic [15:0] cap_ref [HA*VA];
    int nx, nfirst, ndone, nbad, nstall, lat, nafter, nbusy_bad;

    // Run one frame on u_a. poke >= 0 pulses start at that cycle; poke == -2 pulses start
    // in the frame_done cycle.
    task automatic run_frame(input logic [1:0] m, input logic [15:0] f, input bit rnd,
                             input int poke);
        logic [15:0] pd;
        logic [8:0]  px, py;
        logic        pf;
        bit          stalled;
        int          since_done;
        nx = 0; nfirst = 0; ndone = 0; nbad = 0; nstall = 0; lat = -1; nafter = 0;
        nbusy_bad = 0; stalled = 0; since_done = -1; pd = '0; px = '0; py = '0; pf = 1'b0;
        @(negedge clk);
        mode = m; fg = f; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 1000 && since_done < 4; cyc++) begin
            if (a_valid && lat < 0) lat = cyc;
            if (stalled && (!a_valid || a_data !== pd || a_x !== px || a_y !== py ||
                            a_first !== pf)) nstall++;
            if (since_done >= 0) begin
                since_done++;
                if (a_valid) nafter++;
            end
            if (a_done) begin
                ndone++;
                if (a_busy || a_valid) nbusy_bad++;
                if (since_done < 0) begin
                    since_done = 0;
                    if (poke == -2) start = 1'b1;
                end
            end
            if (cyc == poke) start = 1'b1;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (a_valid && ready) begin
                if (nx < HA * VA) cap[nx] = a_data;
                if (a_x !== 9'(nx % HA) || a_y !== 9'(nx / HA)) nbad++;
                if (a_first !== (nx == 0)) nbad++;
                if (a_first) nfirst++;
                nx++;
            end
            stalled = a_valid && !ready;
            pd = a_data; px = a_x; py = a_y; pf = a_first;
            @(negedge clk);
            start = 1'b0;
        end
        ready = 1'b1;
    endtask

    task automatic check_frame(input string name, input int m, input int f, input bit rnd);
        int merr;
        merr = 0;
        for (int i = 0; i < HA * VA; i++)
            if (int'(cap[i]) != model(m, f, i % HA, i / HA, HA, 1)) merr++;
        check({name, "_pixels"}, merr, 0);
        check({name, "_count"}, nx, HA * VA);
        check({name, "_first"}, nfirst, 1);
        check({name, "_order"}, nbad, 0);
        check({name, "_done_once"}, ndone, 1);
        check({name, "_busy_with_done"}, nbusy_bad, 0);
        check({name, "_no_extra"}, nafter, 0);
        check({name, "_stall_stable"}, nstall, 0);
        if (!rnd) check({name, "_latency"}, lat, 0);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [15:0] f;
        int          px;
        int          py;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int bc_err, b_last, c_last, b_dc, c_dc, ndiff;
        logic [15:0] b_end, c_end;

        vecs[0]  = '{2'd2, 16'hF800,  2, 0, 16'h07FF};
        vecs[1]  = '{2'd2, 16'hF800,  2, 2, 16'hF800};
        vecs[2]  = '{2'd2, 16'hF800,  0, 0, 16'hF800};
        vecs[3]  = '{2'd2, 16'hF800,  3, 1, 16'h07FF};
        vecs[4]  = '{2'd2, 16'hF800, 15, 3, 16'hF800};
        vecs[5]  = '{2'd1, 16'h0000,  1, 0, 16'hFFFF};
        vecs[6]  = '{2'd1, 16'h0000,  2, 0, 16'hFFE0};
        vecs[7]  = '{2'd1, 16'h0000,  4, 1, 16'h07FF};
        vecs[8]  = '{2'd1, 16'h0000,  7, 2, 16'h07E0};
        vecs[9]  = '{2'd1, 16'h0000,  8, 3, 16'hF81F};
        vecs[10] = '{2'd1, 16'h0000, 10, 0, 16'hF800};
        vecs[11] = '{2'd1, 16'h0000, 13, 1, 16'h001F};
        vecs[12] = '{2'd1, 16'h0000, 15, 3, 16'h0000};
        vecs[13] = '{2'd1, 16'h0000,  0, 3, 16'hFFFF};
        vecs[14] = '{2'd3, 16'h0000, 15, 3, 16'h0801};
        vecs[15] = '{2'd3, 16'h0000,  7, 2, 16'h0000};
        vecs[16] = '{2'd0, 16'h1234,  9, 2, 16'h1234};

        n_rst = 1'b0; init_done = 1'b1; start = 1'b0; ready = 1'b1; start_big = 1'b0;
        mode = 2'd0; fg = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_state", {a_valid, a_data, a_first, a_done, a_busy, a_x, a_y}, '0);
        n_rst = 1'b1;

        // Gradient on wide and tall geometries, both streaming with ready tied high.
        bc_err = 0; b_last = -1; c_last = -1; b_dc = -1; c_dc = -1; b_end = '0; c_end = '0;
        @(negedge clk); start_big = 1'b1;
        @(negedge clk); start_big = 1'b0;
        for (int cyc = 0; cyc < 4000 && (b_dc < 0 || c_dc < 0); cyc++) begin
            if (b_valid) begin
                if (int'(b_data) != model(3, 0, int'(b_x), int'(b_y), 240, 4)) bc_err++;
                b_last = cyc; b_end = b_data;
            end
            if (c_valid) begin
                if (int'(c_data) != model(3, 0, int'(c_x), int'(c_y), 8, 4)) bc_err++;
                c_last = cyc; c_end = c_data;
            end
            if (b_done && b_dc < 0) b_dc = cyc;
            if (c_done && c_dc < 0) c_dc = cyc;
            @(negedge clk);
        end
        check("grad_model", bc_err, 0);
        check("grad_b_last_pixel", b_end, 16'hE81D);
        check("grad_c_last_pixel", c_end, 16'h0620);
        check("grad_b_done_follows", b_dc, b_last + 1);
        check("grad_c_done_follows", c_dc, c_last + 1);

        run_frame(2'd0, 16'h1234, 1'b0, -1);
        check_frame("solid", 0, 16'h1234, 1'b0);

        foreach (vecs[i]) begin
            run_frame(vecs[i].m, vecs[i].f, 1'b0, -1);
            check($sformatf("vec%0d_px%0d_%0d", i, vecs[i].px, vecs[i].py),
                  cap[vecs[i].py * HA + vecs[i].px], vecs[i].exp);
        end

        run_frame(2'd1, 16'h0000, 1'b0, -1);
        check_frame("bars", 1, 0, 1'b0);
        cap_ref = cap;
        run_frame(2'd1, 16'h0000, 1'b1, -1);
        check_frame("bars_backpressure", 1, 0, 1'b1);
        ndiff = 0;
        for (int i = 0; i < HA * VA; i++) if (cap[i] !== cap_ref[i]) ndiff++;
        check("backpressure_same_seq", ndiff, 0);

        run_frame(2'd2, 16'hF800, 1'b1, -1);
        check_frame("checker_backpressure", 2, 16'hF800, 1'b1);

        run_frame(2'd0, 16'h00FF, 1'b0, 20);
        check_frame("start_while_busy", 0, 16'h00FF, 1'b0);
        run_frame(2'd0, 16'h00FF, 1'b0, -2);
        check_frame("start_on_done", 0, 16'h00FF, 1'b0);

        // Abort after 10 transfers.
        @(negedge clk); mode = 2'd0; fg = 16'h0F0F; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_pre_x", a_x, 9'd10);
        init_done = 1'b0;
        @(negedge clk);
        check("abort_state", {a_valid, a_busy, a_done, a_x, a_y}, '0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_done || a_valid) ndone++;
        end
        check("abort_quiet", ndone, 0);
        init_done = 1'b1;
        run_frame(2'd3, 16'h0000, 1'b0, -1);
        check_frame("after_abort", 3, 0, 1'b0);

        // Start with init_done low is ignored.
        init_done = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_no_init", {a_valid, a_busy}, '0);
        init_done = 1'b1;

        // Reset mid-frame.
        @(negedge clk); mode = 2'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("midframe_busy", a_busy, 1'b1);
        n_rst = 1'b0;
        @(negedge clk);
        check("midframe_reset", {a_valid, a_data, a_first, a_done, a_busy, a_x, a_y}, '0);
        n_rst = 1'b1;
        run_frame(2'd1, 16'h0000, 1'b0, -1);
        check_frame("after_reset", 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
